// File: rtl/debounce_edge_pkg.sv
// debounce_edge_pkg
// Shared constants for the debouncer: FSM state codes and the default
// qualification length. No ports; imported by debounce_edge.
package debounce_edge_pkg;

    // 2-bit binary state encoding; all four codes are legal states.
    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    // Consecutive synchronized cycles needed to accept a level change.
    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    // Width of the stability counter.
    localparam int unsigned CNT_W_DEFAULT = 5;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two chained D flip-flops that bring an asynchronous 1-bit signal into the
// clk domain.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset (both stages clear to 0)
//   d   - asynchronous input
//   q   - synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge
// Debounces a raw, bouncy 1-bit input. The input is synchronized by
// sync_2ff, then an FSM with a stability counter accepts a new value only
// after it has been seen for STABLE_CYCLES consecutive synchronized cycles.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous, active-high reset
//   din      - raw asynchronous input
//   level    - debounced level
//   rise     - one-cycle pulse when level goes 0->1
//   fall     - one-cycle pulse when level goes 1->0
//   rise_cnt - count of accepted rising edges, wraps 255->0
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] rise_cnt
);

    // Counter value on the cycle that completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync2;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, rise_d, fall_d;
    logic [7:0]       rise_cnt_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync2)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        rise_cnt_d = rise_cnt;
        case (state_q)
            ST_IDLE_LOW: begin
                if (sync2) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync2) begin
                    // Bounce: drop back without touching level.
                    state_d = ST_IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE_HIGH;
                    cnt_d      = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                    rise_cnt_d = rise_cnt + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE_HIGH: begin
                if (!sync2) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (sync2) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE_LOW;
            cnt_q    <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            rise_cnt <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level    <= level_d;
            rise     <= rise_d;
            fall     <= fall_d;
            rise_cnt <= rise_cnt_d;
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge
// Cycle-accurate scoreboard bench for debounce_edge with STABLE_CYCLES=4.
// A behavioural model (input delay line plus run-length of "differs from
// level") predicts every cycle's outputs; predictions are queued when the
// input is driven and compared after the following clock edge.
module tb_debounce_edge;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] rise_cnt;

    typedef struct packed {
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] rcnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_rise   = 0;
    int n_fall   = 0;
    int step_idx = 0;

    // Model state
    logic       m_s1    = 1'b0;
    logic       m_s2    = 1'b0;
    logic       m_level = 1'b0;
    logic [7:0] m_rcnt  = 8'd0;
    int         m_run   = 0;

    debounce_edge #(
        .STABLE_CYCLES (S),
        .CNT_W         (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_idx);
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic d, input logic r);
        exp_t e;
        @(negedge clk);
        din = d;
        rst = r;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (r) begin
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_level = 1'b0;
            m_rcnt  = 8'd0;
            m_run   = 0;
        end else begin
            // The decision at this edge uses the value already in stage 2.
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == S) begin
                    m_level = m_s2;
                    m_run   = 0;
                    if (m_s2) begin
                        e.rise = 1'b1;
                        m_rcnt = m_rcnt + 8'd1;
                    end else begin
                        e.fall = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
        e.level = m_level;
        e.rcnt  = m_rcnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        step_idx++;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("level", {31'd0, level}, {31'd0, e.level});
            check("rise", {31'd0, rise}, {31'd0, e.rise});
            check("fall", {31'd0, fall}, {31'd0, e.fall});
            check("rise_cnt", {24'd0, rise_cnt}, {24'd0, e.rcnt});
        end
        if (rise) n_rise++;
        if (fall) n_fall++;
    endtask

    // Hold din for n cycles; report the 1-based step of the first pulse seen.
    task automatic hold(input logic d, input int n, output int first_pulse);
        first_pulse = 0;
        for (int i = 1; i <= n; i++) begin
            step(d, 1'b0);
            if (first_pulse == 0 && (rise || fall)) first_pulse = i;
        end
    endtask

    int p;
    int r0;
    int f0;

    initial begin
        logic [10:0] bounce;
        din = 1'b0;
        rst = 1'b1;

        // 1. Reset with din toggling
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("reset_level", {31'd0, level}, 32'd0);
        check("reset_rise_cnt", {24'd0, rise_cnt}, 32'd0);
        hold(1'b0, 6, p);
        check("reset_no_pulse", p, 0);

        // 2. Clean press
        r0 = n_rise;
        hold(1'b1, 10, p);
        check("press_latency", p, 6);
        check("press_rises", n_rise - r0, 1);
        check("press_rise_cnt", {24'd0, rise_cnt}, 32'd1);

        // 4. Clean release
        f0 = n_fall;
        hold(1'b0, 10, p);
        check("release_latency", p, 6);
        check("release_falls", n_fall - f0, 1);
        check("release_rise_cnt", {24'd0, rise_cnt}, 32'd1);

        // 3. Bounce on press
        r0 = n_rise;
        bounce = 11'b11111011011;  // applied LSB first: 1,1,0,1,1,0,1,1,1,1,1
        for (int i = 0; i < 11; i++) begin
            step(bounce[i], 1'b0);
            if (i < 9) check("bounce_no_rise", {31'd0, rise}, 32'd0);
        end
        hold(1'b1, 6, p);
        check("bounce_rises", n_rise - r0, 1);
        check("bounce_rise_cnt", {24'd0, rise_cnt}, 32'd2);
        hold(1'b0, 10, p);

        // 5. Reset mid-qualification (WAIT_HIGH, cnt=2)
        r0 = n_rise;
        hold(1'b1, 4, p);
        step(1'b1, 1'b1);
        check("midrst_level", {31'd0, level}, 32'd0);
        check("midrst_no_rise", n_rise - r0, 0);
        hold(1'b1, 10, p);
        check("midrst_latency", p, 6);
        check("midrst_rise_cnt", {24'd0, rise_cnt}, 32'd1);

        // 6. Wrap after 256 presses
        step(1'b0, 1'b1);
        hold(1'b0, 4, p);
        r0 = n_rise;
        f0 = n_fall;
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 8, p);
            hold(1'b0, 8, p);
        end
        check("wrap_rise_cnt", {24'd0, rise_cnt}, 32'd0);
        check("wrap_rises", n_rise - r0, 256);
        check("wrap_falls", n_fall - f0, 256);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
